regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port general-purpose register file for the pipelined MIPS cores. It is the next generation of the single-write, dual-read register file.
- Adds configurable width, depth and read-port count, plus two write ports (ALU writeback and load writeback).
- Adds write-to-read bypass and a per-register busy scoreboard, so that decode can stall on outstanding multi-cycle loads.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 1, when 1, register 0 reads as 0 and ignores writes and busy-set.
- BYPASS, 1, when 1, same-cycle write data is forwarded to matching reads.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k is at [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed read data, combinational.
- rd_busy  out  NUM_RD  busy bit of each read address, after bypass.
- wa_en  in  1  write port A enable (ALU writeback).
- wa_addr  in  ADDR_W  port A address.
- wa_data  in  DATA_W  port A data.
- wb_en  in  1  write port B enable (load writeback).
- wb_addr  in  ADDR_W  port B address.
- wb_data  in  DATA_W  port B data.
- bs_en  in  1  mark a register busy (load issued).
- bs_addr  in  ADDR_W  register to mark busy.
- busy_vec  out  2**ADDR_W  full scoreboard, registered.

Behaviour:
- Reset, rst_n=0, asynchronous:
  - all registers clear to 0; busy_vec clears to 0.
  - rd_data is forced to 0 and rd_busy to 0 while rst_n=0.
  - deassertion takes effect at the next clk edge.
- Writes happen on the rising clk edge when enable=1.
  - Port A and port B to the same address in the same cycle: port B (load) wins.
  - With ZERO_REG=1, writes to address 0 are discarded.
- Reads are combinational from the array, zero cycles.
  - With ZERO_REG=1, address 0 returns 0 and busy 0 regardless of anything else.
- Bypass (BYPASS=1):
  - if wb_en and wb_addr==rd_addr[k], rd_data[k]=wb_data.
  - else if wa_en and wa_addr==rd_addr[k], rd_data[k]=wa_data.
  - else rd_data[k] is the array value.
  - With BYPASS=0, read data is the pre-edge array value, i.e. the new value appears one cycle later.
- Scoreboard:
  - at each edge, busy[bs_addr] is set when bs_en=1.
  - busy[x] is cleared when a write (A or B) targets x.
  - Set and clear of the same address in the same cycle: set wins, because a new load is outstanding.
  - Re-setting an already busy register is harmless; it stays 1.
- rd_busy[k]:
  - equals busy[rd_addr[k]], except that it reads 0 when BYPASS=1 and a same-cycle write to that address is present (the write clears it and the data is forwarded).
  - bs_en in the same cycle does not affect rd_busy; busy takes effect the next cycle.
- Both write enables low and bs_en low: the state holds.
- Out-of-range addresses cannot occur (depth = 2**ADDR_W).

Decomposition:
- Package regfile_pkg holds:
  - default DATA_W / ADDR_W constants.
  - the ZERO_ADDR constant.
  - a function for packed-port slicing (port index to bit offset).
- One sub-module, regfile_rd_port, instantiated NUM_RD times via generate. Each instance performs address compare, bypass priority mux, zero-register override and rd_busy generation for one read port.
- Array storage and scoreboard stay in the top level.

Test Plan:
- Reset mid-run:
  - stimulus: write 0xDEADBEEF to r5, set busy r5, pulse rst_n low between edges.
  - required: rd_data=0 immediately; after release, r5 reads 0 and busy_vec=0.
- Dual write collision:
  - stimulus: wa r7=0x11111111 and wb r7=0x22222222 in the same cycle.
  - required: the next-cycle read of r7 returns 0x22222222.
- Bypass:
  - stimulus: wa r3=0x0000ABCD with rd_addr[0]=3 in the same cycle.
  - required: rd_data[0]=0x0000ABCD combinationally; with BYPASS=0, rd_data[0] shows the old value that cycle and 0x0000ABCD the next.
- Zero register:
  - stimulus: write r0=0xFFFFFFFF and set busy r0.
  - required: r0 reads 0, busy_vec[0]=0, rd_busy=0.
- Scoreboard:
  - stimulus: bs r9; next cycle read r9; then wb r9=0x12345678.
  - required: rd_busy=1 the cycle after the set; during the wb cycle rd_busy=0 and rd_data=0x12345678; busy_vec[9]=0 afterwards.
- Set/clear race:
  - stimulus: bs_en r4 and wa r4 in the same cycle.
  - required: r4 is written and busy_vec[4]=1 afterwards.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
// Default geometry, the hard-wired zero register index and packed-port slicing.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int ZERO_ADDR  = 0;

    // Bit offset of port `port` inside a packed bus of `width`-bit fields.
    function automatic int port_off(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Read, write and scoreboard bus of the multi-port register file.
// The master side (decode and writeback) drives requests; the slave side is the register file.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = 2
) ();

    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wa_en;
    logic [ADDR_W-1:0]        wa_addr;
    logic [DATA_W-1:0]        wa_data;
    logic                     wb_en;
    logic [ADDR_W-1:0]        wb_addr;
    logic [DATA_W-1:0]        wb_data;
    logic                     bs_en;
    logic [ADDR_W-1:0]        bs_addr;
    logic [2**ADDR_W-1:0]     busy_vec;

    modport master (
        output rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data, bs_en, bs_addr,
        input  rd_data, rd_busy, busy_vec
    );

    modport slave (
        input  rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data, bs_en, bs_addr,
        output rd_data, rd_busy, busy_vec
    );

endinterface

// File: rtl/regfile_rd_port.sv
// One combinational read port: write bypass with load priority, zero-register
// override and busy reporting for the addressed register.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              i_rst_n,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_mem_data,
    input  logic              i_busy,
    input  logic              i_wa_en,
    input  logic [ADDR_W-1:0] i_wa_addr,
    input  logic [DATA_W-1:0] i_wa_data,
    input  logic              i_wb_en,
    input  logic [ADDR_W-1:0] i_wb_addr,
    input  logic [DATA_W-1:0] i_wb_data,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_busy
);

    logic w_hit_a;
    logic w_hit_b;
    logic w_is_zero;

    assign w_hit_a   = i_wa_en && (i_wa_addr == i_addr);
    assign w_hit_b   = i_wb_en && (i_wb_addr == i_addr);
    assign w_is_zero = (ZERO_REG != 0) && (i_addr == ADDR_W'(ZERO_ADDR));

    always_comb begin
        o_rd_data = i_mem_data;
        o_rd_busy = i_busy;
        if (BYPASS != 0) begin
            if (w_hit_b) begin
                o_rd_data = i_wb_data;
            end else if (w_hit_a) begin
                o_rd_data = i_wa_data;
            end
            // A same-cycle write retires the pending load, so decode need not stall.
            if (w_hit_a || w_hit_b) begin
                o_rd_busy = 1'b0;
            end
        end
        if (w_is_zero || !i_rst_n) begin
            o_rd_data = '0;
            o_rd_busy = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports (ALU, load), NUM_RD bypassed read
// ports and a per-register busy scoreboard for outstanding loads.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_mp_if.slave  bus
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic [DEPTH-1:0]  w_busy_next;
    logic              w_wa_ok;
    logic              w_wb_ok;
    logic              w_bs_ok;

    assign w_wa_ok = bus.wa_en && !((ZERO_REG != 0) && (bus.wa_addr == ADDR_W'(ZERO_ADDR)));
    assign w_wb_ok = bus.wb_en && !((ZERO_REG != 0) && (bus.wb_addr == ADDR_W'(ZERO_ADDR)));
    assign w_bs_ok = bus.bs_en && !((ZERO_REG != 0) && (bus.bs_addr == ADDR_W'(ZERO_ADDR)));

    // Port B is written last so a load wins a same-address collision with the ALU.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_wa_ok) begin
                r_mem[bus.wa_addr] <= bus.wa_data;
            end
            if (w_wb_ok) begin
                r_mem[bus.wb_addr] <= bus.wb_data;
            end
        end
    end

    // Set is applied after the clears: a newly issued load outranks a retiring write.
    always_comb begin
        w_busy_next = r_busy;
        if (w_wa_ok) begin
            w_busy_next[bus.wa_addr] = 1'b0;
        end
        if (w_wb_ok) begin
            w_busy_next[bus.wb_addr] = 1'b0;
        end
        if (w_bs_ok) begin
            w_busy_next[bus.bs_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    assign bus.busy_vec = r_busy;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            localparam int A_OFF = port_off(gi, ADDR_W);
            localparam int D_OFF = port_off(gi, DATA_W);

            logic [ADDR_W-1:0] w_addr;
            logic [DATA_W-1:0] w_data;
            logic              w_busy;

            assign w_addr = bus.rd_addr[A_OFF +: ADDR_W];

            regfile_rd_port #(
                .DATA_W   (DATA_W),
                .ADDR_W   (ADDR_W),
                .ZERO_REG (ZERO_REG),
                .BYPASS   (BYPASS)
            ) u_rd_port (
                .i_rst_n    (rst_n),
                .i_addr     (w_addr),
                .i_mem_data (r_mem[w_addr]),
                .i_busy     (r_busy[w_addr]),
                .i_wa_en    (bus.wa_en),
                .i_wa_addr  (bus.wa_addr),
                .i_wa_data  (bus.wa_data),
                .i_wb_en    (bus.wb_en),
                .i_wb_addr  (bus.wb_addr),
                .i_wb_data  (bus.wb_data),
                .o_rd_data  (w_data),
                .o_rd_busy  (w_busy)
            );

            assign bus.rd_data[D_OFF +: DATA_W] = w_data;
            assign bus.rd_busy[gi]              = w_busy;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypassing and one non-bypassing instance
// share stimulus; expected values go through a scoreboard queue.
module tb_regfile_mp;
    import regfile_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NR*AW-1:0] t_rd_addr;
    logic             t_wa_en, t_wb_en, t_bs_en;
    logic [AW-1:0]    t_wa_addr, t_wb_addr, t_bs_addr;
    logic [DW-1:0]    t_wa_data, t_wb_data;

    regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus_byp ();
    regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus_nob ();

    assign bus_byp.rd_addr = t_rd_addr;  assign bus_nob.rd_addr = t_rd_addr;
    assign bus_byp.wa_en   = t_wa_en;    assign bus_nob.wa_en   = t_wa_en;
    assign bus_byp.wa_addr = t_wa_addr;  assign bus_nob.wa_addr = t_wa_addr;
    assign bus_byp.wa_data = t_wa_data;  assign bus_nob.wa_data = t_wa_data;
    assign bus_byp.wb_en   = t_wb_en;    assign bus_nob.wb_en   = t_wb_en;
    assign bus_byp.wb_addr = t_wb_addr;  assign bus_nob.wb_addr = t_wb_addr;
    assign bus_byp.wb_data = t_wb_data;  assign bus_nob.wb_data = t_wb_data;
    assign bus_byp.bs_en   = t_bs_en;    assign bus_nob.bs_en   = t_bs_en;
    assign bus_byp.bs_addr = t_bs_addr;  assign bus_nob.bs_addr = t_bs_addr;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_byp)
    );

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(0)) u_dut_nob (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_nob)
    );

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] model [32];

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: observed %h expected <queued entry>", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.exp) else begin
                n_err++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
            end
            if (obs === e.exp) $display("ok   %s: %h", e.tag, obs);
        end
    endtask

    task automatic idle();
        t_wa_en = 1'b0; t_wa_addr = '0; t_wa_data = '0;
        t_wb_en = 1'b0; t_wb_addr = '0; t_wb_data = '0;
        t_bs_en = 1'b0; t_bs_addr = '0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        t_rd_addr = {a1, a0};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        set_rd(5'd1, 5'd0);
        // Reset asserted with a live bypass candidate: outputs must still read 0.
        t_wa_en = 1'b1; t_wa_addr = 5'd1; t_wa_data = 32'h0000AAAA;
        push("reset_rd_data0", 32'h0);
        push("reset_rd_busy", 32'h0);
        push("reset_busy_vec", 32'h0);
        #2;
        check(bus_byp.rd_data[31:0]);
        check({30'b0, bus_byp.rd_busy});
        check(bus_byp.busy_vec);
        idle();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset mid-run
        t_wa_en = 1'b1; t_wa_addr = 5'd5; t_wa_data = 32'hDEADBEEF;
        t_bs_en = 1'b1; t_bs_addr = 5'd5;
        tick();
        idle(); set_rd(5'd5, 5'd0);
        push("r5_written", 32'hDEADBEEF);
        push("r5_busy_vec", 32'h0000_0020);
        #1;
        check(bus_byp.rd_data[31:0]);
        check(bus_byp.busy_vec);
        rst_n = 1'b0;
        push("midreset_rd_data0", 32'h0);
        push("midreset_rd_busy", 32'h0);
        #1;
        check(bus_byp.rd_data[31:0]);
        check({30'b0, bus_byp.rd_busy});
        #1;
        rst_n = 1'b1;
        tick();
        push("after_reset_r5", 32'h0);
        push("after_reset_busy_vec", 32'h0);
        #1;
        check(bus_byp.rd_data[31:0]);
        check(bus_byp.busy_vec);

        // Dual write collision: load port wins, also on the bypass path
        t_wa_en = 1'b1; t_wa_addr = 5'd7; t_wa_data = 32'h11111111;
        t_wb_en = 1'b1; t_wb_addr = 5'd7; t_wb_data = 32'h22222222;
        set_rd(5'd0, 5'd7);
        push("collision_bypass_rd1", 32'h22222222);
        #1;
        check(bus_byp.rd_data[63:32]);
        tick();
        idle(); set_rd(5'd7, 5'd0);
        push("collision_r7", 32'h22222222);
        push("collision_r7_nob", 32'h22222222);
        #1;
        check(bus_byp.rd_data[31:0]);
        check(bus_nob.rd_data[31:0]);

        // Bypass vs. no bypass
        t_wa_en = 1'b1; t_wa_addr = 5'd3; t_wa_data = 32'h0000ABCD;
        set_rd(5'd3, 5'd0);
        push("bypass_rd0", 32'h0000ABCD);
        push("nobypass_old_rd0", 32'h0);
        #1;
        check(bus_byp.rd_data[31:0]);
        check(bus_nob.rd_data[31:0]);
        tick();
        idle();
        push("nobypass_next_rd0", 32'h0000ABCD);
        #1;
        check(bus_nob.rd_data[31:0]);

        // Zero register
        t_wa_en = 1'b1; t_wa_addr = 5'd0; t_wa_data = 32'hFFFFFFFF;
        t_bs_en = 1'b1; t_bs_addr = 5'd0;
        set_rd(5'd0, 5'd0);
        push("zero_bypass_rd0", 32'h0);
        #1;
        check(bus_byp.rd_data[31:0]);
        tick();
        idle();
        push("zero_rd0", 32'h0);
        push("zero_busy_vec", 32'h0);
        push("zero_rd_busy", 32'h0);
        #1;
        check(bus_byp.rd_data[31:0]);
        check(bus_byp.busy_vec);
        check({30'b0, bus_byp.rd_busy});

        // Scoreboard: set r9, observe busy, retire with a load writeback
        t_bs_en = 1'b1; t_bs_addr = 5'd9;
        set_rd(5'd9, 5'd7);
        push("bs_same_cycle_rd_busy", 32'h0);
        #1;
        check({30'b0, bus_byp.rd_busy});
        tick();
        idle();
        push("bs_next_rd_busy", 32'h1);
        push("bs_next_busy_vec", 32'h0000_0200);
        #1;
        check({30'b0, bus_byp.rd_busy});
        check(bus_byp.busy_vec);
        tick();
        t_wb_en = 1'b1; t_wb_addr = 5'd9; t_wb_data = 32'h12345678;
        push("wb_cycle_rd_busy", 32'h0);
        push("wb_cycle_rd_data0", 32'h12345678);
        push("wb_cycle_nob_rd_busy", 32'h1);
        push("wb_cycle_nob_rd_data0", 32'h0);
        #1;
        check({30'b0, bus_byp.rd_busy});
        check(bus_byp.rd_data[31:0]);
        check({30'b0, bus_nob.rd_busy});
        check(bus_nob.rd_data[31:0]);
        tick();
        idle();
        push("wb_after_busy_vec", 32'h0);
        push("wb_after_r9", 32'h12345678);
        #1;
        check(bus_byp.busy_vec);
        check(bus_byp.rd_data[31:0]);

        // Set/clear race on r4: data lands, busy stays set
        t_bs_en = 1'b1; t_bs_addr = 5'd4;
        t_wa_en = 1'b1; t_wa_addr = 5'd4; t_wa_data = 32'hCAFE0004;
        tick();
        idle(); set_rd(5'd4, 5'd3);
        push("race_r4", 32'hCAFE0004);
        push("race_busy_vec", 32'h0000_0010);
        push("race_rd_busy", 32'h1);
        push("race_nob_busy_vec", 32'h0000_0010);
        #1;
        check(bus_byp.rd_data[31:0]);
        check(bus_byp.busy_vec);
        check({30'b0, bus_byp.rd_busy});
        check(bus_nob.busy_vec);

        // Mixed writes on both ports, read back through both read ports
        for (int i = 0; i < 4; i++) begin
            logic [AW-1:0] a;
            a = AW'(10 + i);
            model[a] = $urandom;
            idle();
            if (i % 2 == 0) begin
                t_wa_en = 1'b1; t_wa_addr = a; t_wa_data = model[a];
            end else begin
                t_wb_en = 1'b1; t_wb_addr = a; t_wb_data = model[a];
            end
            tick();
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            logic [AW-1:0] a;
            logic [AW-1:0] b;
            a = AW'(10 + i);
            b = AW'(10 + ((i + 1) % 4));
            set_rd(a, b);
            push("readback_rd0", model[a]);
            push("readback_rd1", model[b]);
            #1;
            check(bus_byp.rd_data[31:0]);
            check(bus_byp.rd_data[63:32]);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
